// File: rtl/eth_fcs_engine.sv
// Ethernet FCS engine: IEEE 802.3 CRC-32 at one byte per cycle. TX pads short frames and
// appends the FCS; RX checks the FCS and can strip the trailing four bytes from the output.
module eth_fcs_engine #(
    parameter int MIN_BYTES = 60,
    parameter bit STRIP_FCS = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_mode,
    input  logic       i_dv,
    input  logic [7:0] i_data,
    output logic       o_dv,
    output logic [7:0] o_data,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_fcs_ok,
    output logic       o_overrun
);

    typedef enum logic [2:0] {S_IDLE, S_DATA, S_PAD, S_FCS, S_GAP} state_t;

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [15:0] MIN_W       = 16'(MIN_BYTES);

    state_t      state;
    logic [31:0] crc;
    logic [15:0] cnt;
    logic        mode_q;
    logic [1:0]  fcs_idx;
    logic [7:0]  dat_p0, dat_p1, dat_p2, dat_p3;
    logic        vld_p0, vld_p1, vld_p2, vld_p3;

    logic        accept, frame_rx, shift_en, pad_need, pad_last;
    logic [15:0] cnt_inc;
    logic [31:0] crc_data, crc_pad, fcs_word;
    logic [7:0]  fcs_byte;

    function automatic logic [31:0] crc_fold(input logic [31:0] crc_in, input logic [7:0] byte_in);
        logic [31:0] c;
        c = crc_in ^ {24'd0, byte_in};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    assign accept   = i_dv && (state == S_IDLE || state == S_DATA);
    assign frame_rx = (state == S_IDLE) ? i_mode : mode_q;
    assign shift_en = accept && frame_rx && STRIP_FCS;
    assign cnt_inc  = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    assign crc_data = crc_fold(crc, i_data);
    assign crc_pad  = crc_fold(crc, 8'h00);
    assign fcs_word = ~crc;
    assign fcs_byte = fcs_word[{fcs_idx, 3'b000} +: 8];
    assign pad_need = (cnt < MIN_W);
    assign pad_last = (cnt_inc >= MIN_W);

    // Strip delay line: p0 newest .. p3 oldest; a byte leaves only once four newer ones exist
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            dat_p0 <= 8'h00;
            dat_p1 <= 8'h00;
            dat_p2 <= 8'h00;
            dat_p3 <= 8'h00;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
        end else if (state == S_GAP) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
        end else if (shift_en) begin
            dat_p0 <= i_data;
            dat_p1 <= dat_p0;
            dat_p2 <= dat_p1;
            dat_p3 <= dat_p2;
            vld_p0 <= 1'b1;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            vld_p3 <= vld_p2;
        end
    end

    // Frame control and registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= S_IDLE;
            crc       <= CRC_INIT;
            cnt       <= 16'd0;
            mode_q    <= 1'b0;
            fcs_idx   <= 2'd0;
            o_dv      <= 1'b0;
            o_data    <= 8'h00;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_fcs_ok  <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_dv      <= 1'b0;
            o_data    <= 8'h00;
            o_done    <= 1'b0;
            o_overrun <= i_dv && (state == S_PAD || state == S_FCS || state == S_GAP);

            if (accept) begin
                if (shift_en) begin
                    o_dv   <= vld_p3;
                    o_data <= vld_p3 ? dat_p3 : 8'h00;
                end else begin
                    o_dv   <= 1'b1;
                    o_data <= i_data;
                end
            end

            case (state)
                S_IDLE: begin
                    crc <= CRC_INIT;
                    if (i_dv) begin
                        state  <= S_DATA;
                        mode_q <= i_mode;
                        cnt    <= 16'd1;
                        crc    <= crc_data;
                        o_busy <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (i_dv) begin
                        crc <= crc_data;
                        cnt <= cnt_inc;
                    end else if (mode_q) begin
                        o_done   <= 1'b1;
                        o_fcs_ok <= (crc == CRC_RESIDUE) && (cnt >= 16'd5);
                        o_busy   <= 1'b0;
                        state    <= S_GAP;
                    end else if (pad_need) begin
                        // First pad byte goes out on the cycle right after the last data byte
                        o_dv    <= 1'b1;
                        crc     <= crc_pad;
                        cnt     <= cnt_inc;
                        fcs_idx <= 2'd0;
                        state   <= pad_last ? S_FCS : S_PAD;
                    end else begin
                        o_dv    <= 1'b1;
                        o_data  <= fcs_word[7:0];
                        fcs_idx <= 2'd1;
                        state   <= S_FCS;
                    end
                end
                S_PAD: begin
                    o_dv <= 1'b1;
                    crc  <= crc_pad;
                    cnt  <= cnt_inc;
                    if (pad_last) state <= S_FCS;
                end
                S_FCS: begin
                    o_dv    <= 1'b1;
                    o_data  <= fcs_byte;
                    fcs_idx <= fcs_idx + 2'd1;
                    if (fcs_idx == 2'd3) begin
                        o_done   <= 1'b1;
                        o_fcs_ok <= 1'b0;
                        o_busy   <= 1'b0;
                        state    <= S_GAP;
                    end
                end
                S_GAP: begin
                    crc   <= CRC_INIT;
                    cnt   <= 16'd0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_fcs_engine.sv
// Bench for eth_fcs_engine: two instances (MIN_BYTES=0/STRIP_FCS=1 and MIN_BYTES=60/STRIP_FCS=0)
// driven with directed and random frames, compared against a frame-level CRC-32 model.
module tb_eth_fcs_engine;

    typedef logic [7:0] byte_t;
    typedef byte_t bq_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic  rst[2];
    logic  mode_in[2];
    logic  dv[2];
    byte_t data[2];
    logic  o_dv_w[2];
    byte_t o_data_w[2];
    logic  o_busy_w[2];
    logic  o_done_w[2];
    logic  o_ok_w[2];
    logic  o_ov_w[2];

    eth_fcs_engine #(.MIN_BYTES(0), .STRIP_FCS(1'b1)) dut_a (
        .i_clk(clk), .i_rst(rst[0]), .i_mode(mode_in[0]), .i_dv(dv[0]), .i_data(data[0]),
        .o_dv(o_dv_w[0]), .o_data(o_data_w[0]), .o_busy(o_busy_w[0]), .o_done(o_done_w[0]),
        .o_fcs_ok(o_ok_w[0]), .o_overrun(o_ov_w[0])
    );

    eth_fcs_engine #(.MIN_BYTES(60), .STRIP_FCS(1'b0)) dut_b (
        .i_clk(clk), .i_rst(rst[1]), .i_mode(mode_in[1]), .i_dv(dv[1]), .i_data(data[1]),
        .o_dv(o_dv_w[1]), .o_data(o_data_w[1]), .o_busy(o_busy_w[1]), .o_done(o_done_w[1]),
        .o_fcs_ok(o_ok_w[1]), .o_overrun(o_ov_w[1])
    );

    int checks = 0;
    int failures = 0;

    bq_t   outq0, outq1;
    int    done_cnt[2];
    int    ov_cnt[2];
    int    run_len[2];
    int    done_run[2];
    logic  done_ok[2];
    byte_t done_byte[2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (o_dv_w[d]) begin
                if (d == 0) outq0.push_back(o_data_w[d]);
                else outq1.push_back(o_data_w[d]);
                run_len[d] <= run_len[d] + 1;
            end else begin
                run_len[d] <= 0;
            end
            if (o_done_w[d]) begin
                done_cnt[d]  <= done_cnt[d] + 1;
                done_ok[d]   <= o_ok_w[d];
                done_byte[d] <= o_data_w[d];
                done_run[d]  <= o_dv_w[d] ? run_len[d] + 1 : 0;
            end
            if (o_ov_w[d]) ov_cnt[d] <= ov_cnt[d] + 1;
        end
    end

    function automatic int min_of(input int d);
        return (d == 0) ? 0 : 60;
    endfunction

    function automatic bit strip_of(input int d);
        return (d == 0);
    endfunction

    function automatic int out_size(input int d);
        return (d == 0) ? outq0.size() : outq1.size();
    endfunction

    function automatic bq_t get_out(input int d, input int st);
        bq_t r;
        if (d == 0) begin
            for (int k = st; k < outq0.size(); k++) r.push_back(outq0[k]);
        end else begin
            for (int k = st; k < outq1.size(); k++) r.push_back(outq1[k]);
        end
        return r;
    endfunction

    // Bit-serial CRC-32 over a whole message; returns the transmitted FCS value.
    function automatic logic [31:0] crc32_ref(input bq_t q);
        logic [31:0] c;
        logic fb;
        c = 32'hFFFF_FFFF;
        foreach (q[k]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ q[k][b];
                c = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return ~c;
    endfunction

    function automatic bq_t tx_model(input bq_t p, input int minb);
        bq_t q;
        logic [31:0] c;
        q = p;
        while (q.size() < minb) q.push_back(8'h00);
        c = crc32_ref(q);
        for (int k = 0; k < 4; k++) q.push_back(c[8*k +: 8]);
        return q;
    endfunction

    function automatic bit rx_ok_model(input bq_t f);
        bq_t body;
        logic [31:0] got;
        if (f.size() < 5) return 1'b0;
        for (int k = 0; k < f.size() - 4; k++) body.push_back(f[k]);
        got = {f[f.size()-1], f[f.size()-2], f[f.size()-3], f[f.size()-4]};
        return crc32_ref(body) == got;
    endfunction

    function automatic bq_t rx_out_model(input bq_t f, input bit strip);
        bq_t r;
        if (!strip) return f;
        for (int k = 0; k < f.size() - 4; k++) r.push_back(f[k]);
        return r;
    endfunction

    function automatic int first_diff(input bq_t a, input bq_t b);
        int n;
        n = (a.size() < b.size()) ? a.size() : b.size();
        for (int k = 0; k < n; k++) if (a[k] !== b[k]) return k;
        if (a.size() != b.size()) return n;
        return -1;
    endfunction

    // Drive one contiguous frame; i_mode is randomised after the first byte.
    task automatic run_frame(input int d, input bit mode, input bq_t fr);
        int start;
        int budget;
        start = done_cnt[d];
        for (int i = 0; i < fr.size(); i++) begin
            @(negedge clk);
            dv[d]      = 1'b1;
            data[d]    = fr[i];
            mode_in[d] = (i == 0) ? mode : 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        dv[d]   = 1'b0;
        data[d] = 8'($urandom);
        budget  = 0;
        while (done_cnt[d] == start && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 300) begin
            checks++;
            failures++;
            $display("FAIL frame_timeout dut=%0d got no o_done, required one within 300 cycles", d);
        end
        repeat (2) @(negedge clk);
    endtask

    bq_t msg9;
    bq_t vec13;

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; dv[d] = 1'b0; data[d] = 8'h00; mode_in[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({o_dv_w[d], o_data_w[d], o_busy_w[d], o_done_w[d], o_ok_w[d], o_ov_w[d]} !== 13'd0) begin
                failures++;
                $display("FAIL reset_outputs dut=%0d got=%h required=0", d,
                         {o_dv_w[d], o_data_w[d], o_busy_w[d], o_done_w[d], o_ok_w[d], o_ov_w[d]});
            end
        end
        rst[0] = 1'b0; rst[1] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_tx_vector();
        int st, dn, ov;
        bq_t got;
        st = out_size(0); dn = done_cnt[0]; ov = ov_cnt[0];
        run_frame(0, 1'b0, msg9);
        got = get_out(0, st);
        checks++;
        if (first_diff(got, vec13) != -1) begin
            failures++;
            $display("FAIL tx_vector_bytes diff_at=%0d got_len=%0d required_len=13", first_diff(got, vec13), got.size());
        end
        checks++;
        if (done_byte[0] !== 8'hCB) begin
            failures++; $display("FAIL tx_vector_done_byte got=%h required=cb", done_byte[0]);
        end
        checks++;
        if (done_run[0] != 13) begin
            failures++; $display("FAIL tx_vector_contiguous got=%0d required=13", done_run[0]);
        end
        checks++;
        if (done_ok[0] !== 1'b0) begin
            failures++; $display("FAIL tx_vector_fcs_ok got=%b required=0", done_ok[0]);
        end
        checks++;
        if (ov_cnt[0] != ov) begin
            failures++; $display("FAIL tx_vector_overrun got=%0d required=%0d", ov_cnt[0], ov);
        end
        checks++;
        if (done_cnt[0] != dn + 1) begin
            failures++; $display("FAIL tx_vector_done_count got=%0d required=%0d", done_cnt[0], dn + 1);
        end
        checks++;
        if (o_busy_w[0] !== 1'b0) begin
            failures++; $display("FAIL tx_vector_busy_after got=%b required=0", o_busy_w[0]);
        end
    endtask

    task automatic test_tx_pad();
        int st;
        bq_t got, want;
        st = out_size(1);
        want = tx_model(msg9, 60);
        run_frame(1, 1'b0, msg9);
        got = get_out(1, st);
        checks++;
        if (got.size() != 64) begin
            failures++; $display("FAIL tx_pad_length got=%0d required=64", got.size());
        end
        checks++;
        if (first_diff(got, want) != -1) begin
            failures++; $display("FAIL tx_pad_bytes diff_at=%0d got_len=%0d required_len=%0d", first_diff(got, want), got.size(), want.size());
        end
        checks++;
        if (done_run[1] != 64) begin
            failures++; $display("FAIL tx_pad_contiguous got=%0d required=64", done_run[1]);
        end
        checks++;
        if (done_byte[1] !== want[63]) begin
            failures++; $display("FAIL tx_pad_done_byte got=%h required=%h", done_byte[1], want[63]);
        end
    endtask

    task automatic test_rx_strip();
        int st;
        bq_t got, fr, want;
        fr = vec13;
        st = out_size(0);
        run_frame(0, 1'b1, fr);
        got = get_out(0, st);
        checks++;
        if (first_diff(got, msg9) != -1) begin
            failures++; $display("FAIL rx_strip_bytes diff_at=%0d got_len=%0d required_len=9", first_diff(got, msg9), got.size());
        end
        checks++;
        if (done_ok[0] !== 1'b1) begin
            failures++; $display("FAIL rx_strip_fcs_good got=%b required=1", done_ok[0]);
        end
        fr[3] = fr[3] ^ 8'h01;
        want = msg9;
        want[3] = 8'h35;
        st = out_size(0);
        run_frame(0, 1'b1, fr);
        got = get_out(0, st);
        checks++;
        if (done_ok[0] !== 1'b0) begin
            failures++; $display("FAIL rx_strip_fcs_bad got=%b required=0", done_ok[0]);
        end
        checks++;
        if (first_diff(got, want) != -1) begin
            failures++; $display("FAIL rx_strip_bad_bytes diff_at=%0d got_len=%0d required_len=9", first_diff(got, want), got.size());
        end
    endtask

    task automatic test_rx_nostrip();
        int st;
        bq_t got, shortf;
        st = out_size(1);
        run_frame(1, 1'b1, vec13);
        got = get_out(1, st);
        checks++;
        if (first_diff(got, vec13) != -1) begin
            failures++; $display("FAIL rx_nostrip_bytes diff_at=%0d got_len=%0d required_len=13", first_diff(got, vec13), got.size());
        end
        checks++;
        if (done_ok[1] !== 1'b1) begin
            failures++; $display("FAIL rx_nostrip_fcs got=%b required=1", done_ok[1]);
        end
        shortf = '{8'h26, 8'h39, 8'hF4};
        st = out_size(0);
        run_frame(0, 1'b1, shortf);
        got = get_out(0, st);
        checks++;
        if (got.size() != 0) begin
            failures++; $display("FAIL rx_short_emit got_len=%0d required_len=0", got.size());
        end
        checks++;
        if (done_ok[0] !== 1'b0) begin
            failures++; $display("FAIL rx_short_fcs got=%b required=0", done_ok[0]);
        end
    endtask

    task automatic test_overrun();
        int st, dn, ov, budget;
        bq_t got;
        st = out_size(0); dn = done_cnt[0]; ov = ov_cnt[0];
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            dv[0] = 1'b1; data[0] = msg9[i]; mode_in[0] = 1'b0;
        end
        @(negedge clk);
        dv[0] = 1'b0;
        // Re-assert for the last three FCS cycles and the gap cycle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dv[0] = 1'b1; data[0] = 8'($urandom); mode_in[0] = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        dv[0] = 1'b0;
        budget = 0;
        while (done_cnt[0] == dn && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        repeat (2) @(negedge clk);
        got = get_out(0, st);
        checks++;
        if (ov_cnt[0] - ov != 4) begin
            failures++; $display("FAIL overrun_pulses got=%0d required=4", ov_cnt[0] - ov);
        end
        checks++;
        if (first_diff(got, vec13) != -1) begin
            failures++; $display("FAIL overrun_stream diff_at=%0d got_len=%0d required_len=13", first_diff(got, vec13), got.size());
        end
        checks++;
        if (done_cnt[0] != dn + 1) begin
            failures++; $display("FAIL overrun_done_count got=%0d required=%0d", done_cnt[0], dn + 1);
        end
        st = out_size(0);
        run_frame(0, 1'b0, msg9);
        got = get_out(0, st);
        checks++;
        if (first_diff(got, vec13) != -1) begin
            failures++; $display("FAIL overrun_next_frame diff_at=%0d got_len=%0d required_len=13", first_diff(got, vec13), got.size());
        end
    endtask

    task automatic test_reset_midframe();
        int st, dn;
        bq_t got;
        dn = done_cnt[0];
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            dv[0] = 1'b1; data[0] = msg9[i]; mode_in[0] = 1'b0;
        end
        @(negedge clk);
        dv[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        checks++;
        if ({o_dv_w[0], o_data_w[0], o_busy_w[0]} !== {1'b1, 8'h39, 1'b1}) begin
            failures++; $display("FAIL rst_mid_before got dv/data/busy=%b/%h/%b required=1/39/1", o_dv_w[0], o_data_w[0], o_busy_w[0]);
        end
        rst[0] = 1'b1;
        #1;
        checks++;
        if ({o_dv_w[0], o_data_w[0], o_busy_w[0], o_done_w[0], o_ok_w[0], o_ov_w[0]} !== 13'd0) begin
            failures++; $display("FAIL rst_mid_outputs got=%h required=0",
                                 {o_dv_w[0], o_data_w[0], o_busy_w[0], o_done_w[0], o_ok_w[0], o_ov_w[0]});
        end
        repeat (2) @(negedge clk);
        rst[0] = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt[0] != dn) begin
            failures++; $display("FAIL rst_mid_no_done got=%0d required=%0d", done_cnt[0], dn);
        end
        st = out_size(0);
        run_frame(0, 1'b0, msg9);
        got = get_out(0, st);
        checks++;
        if (first_diff(got, vec13) != -1) begin
            failures++; $display("FAIL rst_mid_next_frame diff_at=%0d got_len=%0d required_len=13", first_diff(got, vec13), got.size());
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int d, st, dn, len;
            bit mode;
            bq_t p, fr, want, got;
            bit want_ok;
            d = n % 2;
            mode = 1'($urandom_range(0, 1));
            p.delete();
            if (!mode) begin
                len = $urandom_range(1, 70);
                for (int k = 0; k < len; k++) p.push_back(8'($urandom));
                fr = p;
                want = tx_model(p, min_of(d));
                want_ok = 1'b0;
            end else begin
                len = $urandom_range(0, 40);
                for (int k = 0; k < len; k++) p.push_back(8'($urandom));
                fr = ($urandom_range(0, 3) != 0) ? tx_model(p, 0) : p;
                if (fr.size() == 0) fr.push_back(8'($urandom));
                if ($urandom_range(0, 3) == 0) begin
                    int idx;
                    idx = $urandom_range(0, fr.size() - 1);
                    fr[idx] = fr[idx] ^ (8'h01 << $urandom_range(0, 7));
                end
                want = rx_out_model(fr, strip_of(d));
                want_ok = rx_ok_model(fr);
            end
            st = out_size(d); dn = done_cnt[d];
            run_frame(d, mode, fr);
            got = get_out(d, st);
            checks++;
            if (first_diff(got, want) != -1) begin
                failures++;
                $display("FAIL random_bytes frame=%0d dut=%0d mode=%0d diff_at=%0d got_len=%0d required_len=%0d",
                         n, d, mode, first_diff(got, want), got.size(), want.size());
            end
            checks++;
            if (done_ok[d] !== want_ok) begin
                failures++; $display("FAIL random_fcs_ok frame=%0d dut=%0d mode=%0d got=%b required=%b", n, d, mode, done_ok[d], want_ok);
            end
            checks++;
            if (done_cnt[d] != dn + 1) begin
                failures++; $display("FAIL random_done_count frame=%0d dut=%0d got=%0d required=%0d", n, d, done_cnt[d], dn + 1);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        msg9  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        vec13 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                  8'h26, 8'h39, 8'hF4, 8'hCB};
        test_reset();
        test_tx_vector();
        test_tx_pad();
        test_rx_strip();
        test_rx_nostrip();
        test_overrun();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eth_fcs_engine.md
ETH_FCS_ENGINE -- requirements
Module: eth_fcs_engine

Interface
REQ-001 SHALL have parameter MIN_BYTES, default 60, minimum TX payload length before FCS (0 disables padding).
REQ-002 SHALL have parameter STRIP_FCS, default 1, RX mode: 1 = final 4 bytes not forwarded on o_dv.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 i_clk  in  1  sole clock, all logic on rising edge.
REQ-005 i_rst  in  1  asynchronous active-high reset.
REQ-006 i_mode  in  1  0 = TX (generate/pad/append), 1 = RX (check); sampled on first byte of frame.
REQ-007 i_dv  in  1  input byte valid; a frame is one contiguous i_dv-high run.
REQ-008 i_data  in  8  input byte, Ethernet bit order (bit 0 first on wire).
REQ-009 o_dv  out  1  output byte valid.
REQ-010 o_data  out  8  output byte.
REQ-011 o_busy  out  1  high from first accepted byte until frame fully emitted/checked.
REQ-012 o_done  out  1  one-cycle pulse on the final cycle of each frame.
REQ-013 o_fcs_ok  out  1  RX: valid with o_done, 1 = FCS correct; TX: always 0.
REQ-014 o_overrun  out  1  one-cycle pulse when i_dv is high while the block cannot accept.

Function
REQ-015 CRC SHALL be IEEE 802.3 CRC-32: poly 0x04C11DB7, reflected, init 0xFFFFFFFF, one byte per cycle, CRC of ASCII "123456789" = 0xCBF43926.
REQ-016 States: IDLE, DATA, PAD, FCS, GAP; encoding free.
REQ-017 IDLE: CRC register held at 0xFFFFFFFF; i_dv high -> DATA, byte folded into CRC, i_mode latched, byte counter = 1.
REQ-018 DATA: each i_dv-high cycle folds byte into CRC and increments 16-bit byte counter, saturating at 0xFFFF.
REQ-019 Pass-through latency SHALL be exactly 1 cycle: o_dv/o_data are i_dv/i_data registered.
REQ-020 TX, i_dv falls in DATA: counter < MIN_BYTES -> PAD, else -> FCS.
REQ-021 PAD: emit 0x00 bytes (o_dv=1), each folded into CRC, until counter = MIN_BYTES, then -> FCS; first pad byte immediately follows last data byte on o_dv.
REQ-022 FCS: emit 4 bytes of ~CRC, least-significant byte first, no o_dv gap; o_done pulses with 4th byte; -> GAP.
REQ-023 RX, i_dv falls in DATA: o_done pulses next cycle, o_fcs_ok = (CRC register == 0xDEBB20E3 after last byte) and counter >= 5; -> GAP.
REQ-024 RX STRIP_FCS=1: output delayed through 4-byte pipeline so last 4 frame bytes never appear; latency becomes 5 cycles; frames < 5 bytes emit nothing.
REQ-025 RX STRIP_FCS=0: all bytes forwarded at 1-cycle latency.
REQ-026 GAP: one cycle, CRC reinitialised, o_busy low, -> IDLE; i_dv high in GAP is not accepted.
REQ-027 i_dv high during PAD, FCS or GAP SHALL pulse o_overrun each such cycle; byte discarded, output stream unaffected.
REQ-028 o_fcs_ok SHALL hold its value until next o_done.
REQ-029 i_mode changes mid-frame SHALL be ignored.

Reset
REQ-030 i_rst SHALL force state IDLE, CRC 0xFFFFFFFF, counter 0, strip pipeline cleared, all outputs 0, asynchronously.
REQ-031 Reset mid-frame SHALL abort with no o_done; first byte after release starts a fresh frame.

Verification
REQ-032 TX, MIN_BYTES=0: "123456789" -> o_data 31..39 then 26 39 F4 CB, o_done with CB, o_overrun never.
REQ-033 TX, MIN_BYTES=60: 9-byte "123456789" -> 9 data + 51 x 0x00 + 4 FCS bytes = 64 contiguous o_dv cycles, FCS matching software CRC of padded frame.
REQ-034 RX, STRIP_FCS=1: "123456789" 26 39 F4 CB -> o_fcs_ok=1, only 31..39 emitted; flip bit 0 of byte 3 -> o_fcs_ok=0.
REQ-035 TX frame followed by i_dv re-asserted during FCS phase -> o_overrun pulses per cycle, FCS bytes intact, next frame accepted after GAP.
REQ-036 i_rst asserted during 2nd FCS byte -> outputs 0 same cycle, no o_done; subsequent "123456789" frame yields 26 39 F4 CB.
